fifo_dispatcher: RTL

- Sits directly downstream of the round-robin selector interface and upstream of the output port.
- Consumes `selector`/`selector_enb`, pops exactly one word from the selected FIFO, and registers that word.
- Presents the word on a valid/ready output handshake, tagged with its source queue.
- Provides the actual dequeue and buffering that turns a scheduling decision into a data transfer.

---
 rtl/fifo_dispatcher_pkg.sv | 26 ++
 rtl/fifo_dispatcher_if.sv | 38 +++
 rtl/dispatch_stat_counter.sv | 24 ++
 rtl/fifo_dispatcher.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fifo_dispatcher_pkg.sv
// Shared types/helpers for the dispatcher and round-robin blocks.
// FSM state codes, queue-id width and one-hot pop encoding.
package fifo_dispatcher_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_SEND = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    SEND = ST_SEND,
    BAD  = 2'b11
  } state_e;

  function automatic int qid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] onehot(
    input int unsigned idx
  );
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/fifo_dispatcher_if.sv
// Selector/FIFO/output bundle between scheduler, FIFOs and sink.
// master: dispatcher side; slave: environment side.
interface fifo_dispatcher_if
  import fifo_dispatcher_pkg::*;
#(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8
);
  localparam int QW = qid_w(QUEUE_QUANTITY);
  localparam int FW = QUEUE_QUANTITY * DATA_BITS;

  logic [QW-1:0]             selector;
  logic                      selector_enb;
  logic [QUEUE_QUANTITY-1:0] buf_empty;
  logic [FW-1:0]             fifo_data;
  logic [QUEUE_QUANTITY-1:0] pop;
  logic [DATA_BITS-1:0]      data_out;
  logic [QW-1:0]             data_src;
  logic                      data_valid;
  logic                      data_ready;
  logic                      busy;

  modport master (
    input  selector, selector_enb,
    input  buf_empty, fifo_data,
    input  data_ready,
    output pop, data_out, data_src,
    output data_valid, busy
  );

  modport slave (
    output selector, selector_enb,
    output buf_empty, fifo_data,
    output data_ready,
    input  pop, data_out, data_src,
    input  data_valid, busy
  );
endinterface

// File: rtl/dispatch_stat_counter.sv
// Saturating event counter, sync active-high reset.
// Ports: clk, rst, inc_i, cnt_o[W]. Built only with DISPATCHER_STATS_EN.
`ifdef DISPATCHER_STATS_EN
module dispatch_stat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
endmodule
`endif

// File: rtl/fifo_dispatcher.sv
// Pops one word from the selected FIFO and offers it on valid/ready.
// Ports: clk, rst, enb, bus (master); DISPATCHER_STATS_EN adds stat_sel/stat_count.
module fifo_dispatcher
  import fifo_dispatcher_pkg::*;
#(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  parameter int CNT_BITS       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
`ifdef DISPATCHER_STATS_EN
  input  logic [qid_w(QUEUE_QUANTITY)-1:0] stat_sel,
  output logic [CNT_BITS-1:0] stat_count,
`endif
  fifo_dispatcher_if.master   bus
);
  localparam int QW = qid_w(QUEUE_QUANTITY);
  localparam int DB = DATA_BITS;

  state_e        state_q, state_d;
  logic [QW-1:0] src_q, src_d;
  logic [QW-1:0] dsrc_q, dsrc_d;
  logic [DB-1:0] dout_q, dout_d;
  logic          vld_q, vld_d;
  logic          go, pop_en;
  logic [31:0]   oh;
  logic          unused_oh;

  assign go = enb && bus.selector_enb
           && (int'(bus.selector) < QUEUE_QUANTITY)
           && !bus.buf_empty[bus.selector];

  assign oh        = onehot(32'(bus.selector));
  assign unused_oh = ^oh;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dsrc_d  = dsrc_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    pop_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          pop_en  = 1'b1;
          src_d   = bus.selector;
          state_d = WAIT;
        end
      end
      // A committed pop always lands, enb or not.
      WAIT: begin
        dout_d  = bus.fifo_data[src_q*DB +: DB];
        dsrc_d  = src_q;
        vld_d   = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (bus.data_ready) begin
          vld_d = 1'b0;
          if (go) begin
            pop_en  = 1'b1;
            src_d   = bus.selector;
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dsrc_q  <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dsrc_q  <= dsrc_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.pop = (pop_en && !rst)
                 ? oh[QUEUE_QUANTITY-1:0] : '0;
  assign bus.data_out   = dout_q;
  assign bus.data_src   = dsrc_q;
  assign bus.data_valid = vld_q;
  assign bus.busy       = (state_q != IDLE);

`ifdef DISPATCHER_STATS_EN
  logic [CNT_BITS-1:0] cnt [QUEUE_QUANTITY];

  for (genvar i = 0; i < QUEUE_QUANTITY; i++) begin : g_cnt
    logic inc;
    assign inc = vld_q && bus.data_ready
              && (dsrc_q == QW'(i));
    dispatch_stat_counter #(.W(CNT_BITS)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (inc),
      .cnt_o (cnt[i])
    );
  end

  assign stat_count = cnt[stat_sel];
`endif

endmodule
